// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - sticky 8-line request capture serialised into a 3-bit index stream
// Fixed-priority or rotating selection; one code per valid/ready handshake.
module encoder_8to3_seq #(
  parameter int N           = 8,
  parameter int W           = 3,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] in,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         any
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d, clear_mask;
  logic [W-1:0]   code_q, code_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   sel, idx, base;
  logic           found;

  // Scan upward from the base index; W-bit addition wraps 7 -> 0 naturally.
  always_comb begin
    base  = ROUND_ROBIN ? ptr_q : '0;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = base + W'(i);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    clear_mask = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          code_d  = sel;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          clear_mask[code_q] = 1'b1;
          valid_d            = 1'b0;
          state_d            = IDLE;
          if (ROUND_ROBIN) ptr_d = code_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh strobe on the line being cleared survives as a re-request.
    pending_d = (pending_q & ~clear_mask) | (enable ? in : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_code  = code_q;
  assign out_valid = valid_q;
  assign pending   = pending_q;
  assign any       = |pending_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - directed and random checks of both priority modes against a reference model
module tb_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst_n, enable, out_ready;
  logic [7:0] in;
  logic [2:0] code0, code1;
  logic       v0, v1, any0, any1;
  logic [7:0] p0, p1;

  int n_asserts = 0;
  int n_fail    = 0;

  bit [7:0] m_pend[2];
  bit       m_valid[2];
  int       m_code[2];
  int       m_ptr[2];
  int       grants0[$];
  int       grants1[$];

  always #5 clk = ~clk;

  encoder_8to3_seq #(.N(8), .W(3), .ROUND_ROBIN(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in),
    .out_code(code0), .out_valid(v0), .out_ready(out_ready),
    .pending(p0), .any(any0)
  );

  encoder_8to3_seq #(.N(8), .W(3), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in),
    .out_code(code1), .out_valid(v1), .out_ready(out_ready),
    .pending(p1), .any(any1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_pend[r] = 8'h00; m_valid[r] = 1'b0; m_code[r] = 0; m_ptr[r] = 0;
    end
  endtask

  // One clock edge of the spec: serve from the old pending set, then merge new strobes.
  task automatic model_step();
    for (int r = 0; r < 2; r++) begin
      bit [7:0] clr;
      bit       hit;
      int       start;
      clr = 8'h00;
      if (m_valid[r]) begin
        if (out_ready) begin
          clr = 8'(1 << m_code[r]);
          m_valid[r] = 1'b0;
          if (r == 1) m_ptr[r] = (m_code[r] + 1) % 8;
        end
      end else if (m_pend[r] != 8'h00) begin
        start = (r == 1) ? m_ptr[r] : 0;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!hit && m_pend[r][(start + k) % 8]) begin
            m_code[r] = (start + k) % 8;
            hit = 1'b1;
          end
        end
        m_valid[r] = 1'b1;
      end
      m_pend[r] = (m_pend[r] & ~clr) | (enable ? in : 8'h00);
    end
  endtask

  task automatic check_model();
    chk("fixed_valid", 32'(v0), 32'(m_valid[0]));
    chk("fixed_code", 32'(code0), m_code[0]);
    chk("fixed_pending", 32'(p0), 32'(m_pend[0]));
    chk("fixed_any", 32'(any0), 32'(m_pend[0] != 8'h00));
    chk("rr_valid", 32'(v1), 32'(m_valid[1]));
    chk("rr_code", 32'(code1), m_code[1]);
    chk("rr_pending", 32'(p1), 32'(m_pend[1]));
    chk("rr_any", 32'(any1), 32'(m_pend[1] != 8'h00));
  endtask

  // Inputs change only at negedge; the model and the DUTs both see them at the posedge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_model();
    if (v0 && out_ready) grants0.push_back(int'(code0));
    if (v1 && out_ready) grants1.push_back(int'(code1));
  endtask

  initial begin
    int   exp_seq[4];
    int   zeros, sevens, alt_ok;
    rst_n = 1'b0; enable = 1'b1; in = 8'hFF; out_ready = 1'b0;
    model_reset();
    cyc(); cyc();
    chk("rst_pending", 32'(p0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);

    // Asynchronous reset between edges, with every line requesting.
    rst_n = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pending", 32'(p0), 32'h0);
    chk("async_rst_valid", 32'(v0), 32'h0);
    chk("async_rst_code", 32'(code0), 32'h0);
    chk("async_rst_any", 32'(any0), 32'h0);
    chk("async_rst_rr_pending", 32'(p1), 32'h0);
    model_reset();
    @(negedge clk);
    in = 8'h00; rst_n = 1'b1; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("post_rst_idle", 32'(v0), 32'h0);

    // Single request on line 5.
    in = 8'h20;
    cyc();
    chk("single_pending", 32'(p0), 32'h20);
    in = 8'h00;
    cyc();
    chk("single_valid", 32'(v0), 32'h1);
    chk("single_code", 32'(code0), 32'h5);
    cyc();
    chk("single_cleared", 32'(p0), 32'h0);
    chk("single_done", 32'(v0), 32'h0);

    // Fixed priority burst.
    grants0.delete(); grants1.delete();
    in = 8'h96;
    cyc();
    in = 8'h00;
    repeat (12) cyc();
    exp_seq = '{1, 2, 4, 7};
    chk("fixed_burst_count", 32'(grants0.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants0.size(); i++) chk("fixed_burst_order", 32'(grants0[i]), 32'(exp_seq[i]));
    chk("fixed_burst_any", 32'(any0), 32'h0);

    // Round robin with lines 0 and 7 held high.
    grants1.delete();
    in = 8'h81;
    repeat (16) cyc();
    zeros = 0; sevens = 0; alt_ok = 1;
    foreach (grants1[i]) begin
      if (grants1[i] == 0) zeros++;
      else if (grants1[i] == 7) sevens++;
      else alt_ok = 0;
      if (i > 0 && grants1[i] == grants1[i-1]) alt_ok = 0;
    end
    chk("rr_alternates", 32'(alt_ok), 32'd1);
    chk("rr_line0_served", 32'(zeros >= 3), 32'd1);
    chk("rr_line7_served", 32'(sevens >= 3), 32'd1);
    in = 8'h00;
    repeat (6) cyc();

    // Backpressure then re-request on the accept edge.
    out_ready = 1'b0;
    in = 8'h08;
    cyc();
    in = 8'h00;
    cyc();
    repeat (5) begin
      cyc();
      chk("bp_valid_held", 32'(v0), 32'h1);
      chk("bp_code_held", 32'(code0), 32'h3);
    end
    out_ready = 1'b1;
    in = 8'h08;
    cyc();
    chk("rereq_pending", 32'(p0[3]), 32'h1);
    chk("rereq_gap", 32'(v0), 32'h0);
    in = 8'h00;
    cyc();
    chk("rereq_valid", 32'(v0), 32'h1);
    chk("rereq_code", 32'(code0), 32'h3);
    repeat (6) cyc();

    // Enable gating.
    enable = 1'b0;
    in = 8'hFF;
    cyc();
    chk("gate_pending", 32'(p0), 32'h0);
    in = 8'h00;
    cyc();
    chk("gate_no_valid", 32'(v0), 32'h0);
    enable = 1'b1; out_ready = 1'b0; in = 8'h04;
    cyc();
    enable = 1'b0; in = 8'h00; out_ready = 1'b1;
    cyc();
    chk("gate_serve_valid", 32'(v0), 32'h1);
    chk("gate_serve_code", 32'(code0), 32'h2);
    cyc();
    chk("gate_serve_cleared", 32'(p0), 32'h0);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
